// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle multiply/divide unit with architectural HI/LO registers.
// One radix-2 shift-add multiply step or one restoring-divide step is done per cycle.
// Signed operations run on magnitudes, and the signs are applied in a single fix-up cycle.
//
// Ports
//   clock     in   system clock, all state on the rising edge
//   reset     in   synchronous, active-low
//   start     in   launch an operation (only honoured in idle)
//   op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      in   multiplicand/dividend, multiplier/divisor
//   wr_hi     in   MTHI strobe (idle only, start has priority)
//   wr_lo     in   MTLO strobe (idle only, start has priority)
//   wdata     in   MTHI/MTLO data
//   busy      out  operation in progress (calc + fix-up)
//   done      out  one-cycle completion pulse
//   div_zero  out  divide by zero flag, valid with done
//   hi, lo    out  HI/LO registers
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;          // quotient/product must be negated
   logic             rem_neg_q, rem_neg_d;  // remainder takes the dividend's sign
   logic [WIDTH-1:0] mcand_q, mcand_d;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;    // product upper half / partial remainder
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;    // multiplier bits / quotient bits
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;

   logic             signed_op;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic             rem_ge;
   logic [2*WIDTH-1:0] prod, prod_neg;

   assign signed_op = ~op[0];
   assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

   // Multiply step: conditional add keeps the carry, then shift {carry,hi,lo} right.
   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

   // Divide step: shift {rem,quo} left, restore by only committing a non-negative difference.
   assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, mcand_q};
   assign rem_ge   = (rem_sh >= {1'b0, mcand_q});

   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_neg = -prod;

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      mcand_d   = mcand_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dz_d      = dz_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (op[1] && (b == '0)) begin
                  state_d = StDone;
                  dz_d    = 1'b1;
               end else begin
                  state_d   = StCalc;
                  is_div_d  = op[1];
                  neg_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rem_neg_d = signed_op & a[WIDTH-1];
                  count_d   = '0;
                  acc_hi_d  = '0;
                  if (op[1]) begin
                     acc_lo_d = abs_a;
                     mcand_d  = abs_b;
                  end else begin
                     acc_lo_d = abs_b;
                     mcand_d  = abs_a;
                  end
               end
            end else begin
               if (wr_hi) hi_d = wdata;
               if (wr_lo) lo_d = wdata;
            end
         end
         StCalc: begin
            if (is_div_q) begin
               if (rem_ge) begin
                  acc_hi_d = rem_diff[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = rem_sh[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) state_d = StFix;
         end
         StFix: begin
            if (is_div_q) begin
               lo_d = neg_q ? -acc_lo_q : acc_lo_q;
               hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
            end else begin
               {hi_d, lo_d} = neg_q ? prod_neg : prod;
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            dz_d    = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= StIdle;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         mcand_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         mcand_q   <= mcand_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dz_q      <= dz_d;
      end
   end

   assign busy     = (state_q == StCalc) || (state_q == StFix);
   assign done     = (state_q == StDone);
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: one WIDTH=32 instance and one WIDTH=8 instance.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        wr_hi, wr_lo;
   logic [31:0] wdata;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   logic        start8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, div_zero8;
   logic [7:0]  hi8, lo8;

   int n_checks = 0;
   int n_errors = 0;

   // Results of the last run_op call
   int   lat, nbusy, ndone;
   logic dz_done, dz_after, hold_bad;

   always #5 clock = ~clock;

   mult_div_unit #(.WIDTH(32)) u_dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mult_div_unit #(.WIDTH(8)) u_dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .wr_hi(1'b0), .wr_lo(1'b0), .wdata(8'h00),
      .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic h, input logic l, input logic [31:0] d);
      @(negedge clock);
      wr_hi = h;
      wr_lo = l;
      wdata = d;
      @(posedge clock);
      #1;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
   endtask

   // Launch one op, then watch a fixed window. Cycle index 1 is the cycle after the start
   // edge. At index inj (if > 0) an illegal start + MTLO is driven for one cycle.
   task run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
               input int inj, input logic wrh);
      logic [31:0] hi0, lo0;
      lat      = -1;
      nbusy    = 0;
      ndone    = 0;
      dz_done  = 1'b0;
      dz_after = 1'b0;
      hold_bad = 1'b0;
      @(negedge clock);
      hi0   = hi;
      lo0   = lo;
      start = 1'b1;
      op    = op_v;
      a     = a_v;
      b     = b_v;
      wr_hi = wrh;
      wdata = 32'h0000_0077;
      @(posedge clock);
      #1;
      start = 1'b0;
      wr_hi = 1'b0;
      a     = 32'h1234_5678;
      b     = 32'h0000_0000;
      op    = 2'b10;
      for (int k = 1; k <= 45; k++) begin
         if (busy) nbusy++;
         if (busy && (hi !== hi0 || lo !== lo0)) hold_bad = 1'b1;
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat     = k;
               dz_done = div_zero;
            end
         end
         if (lat > 0 && k == lat + 1) dz_after = div_zero;
         if (k == inj) begin
            @(negedge clock);
            start = 1'b1;
            op    = 2'b11;
            a     = 32'h0000_0001;
            b     = 32'h0000_0000;
            wr_lo = 1'b1;
            wdata = 32'hDEAD_BEEF;
         end
         @(posedge clock);
         #1;
         if (k == inj) begin
            start = 1'b0;
            wr_lo = 1'b0;
         end
      end
   endtask

   initial begin
      int ndone_rst;
      int lat8;
      reset  = 1'b0;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      wdata  = '0;
      start8 = 1'b0;
      op8    = 2'b00;
      a8     = '0;
      b8     = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_zero, 0);
      check("rst_hilo", {hi, lo}, 64'h0);
      @(negedge clock);
      reset = 1'b1;

      // MULT -3 * 7
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
      check("mult_lat", lat, 34);
      check("mult_busy", nbusy, 33);
      check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      check("mult_hold", hold_bad, 0);

      // MULTU max * max
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      check("multu_busy", nbusy, 33);
      check("multu_ndone", ndone, 1);
      check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // DIV -7 / 2 and 7 / -2
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      check("div_nn_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      check("div_nn_dz", dz_done, 0);
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
      check("div_pn_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

      // DIVU 100 / 7
      run_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
      check("divu_lat", lat, 34);
      check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

      // DIV MIN / -1
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      check("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
      check("div_min_dz", dz_done, 0);

      // MTHI alone leaves LO untouched
      write_reg(1'b1, 1'b0, 32'h0000_ABCD);
      check("mthi_hilo", {hi, lo}, 64'h0000_ABCD_8000_0000);

      // Divide by zero keeps HI/LO
      write_reg(1'b1, 1'b1, 32'd5);
      write_reg(1'b0, 1'b1, 32'd9);
      run_op(2'b11, 32'd100, 32'd0, 0, 1'b0);
      check("dz_lat", lat, 1);
      check("dz_flag", dz_done, 1);
      check("dz_clear", dz_after, 0);
      check("dz_ndone", ndone, 1);
      check("dz_busy", nbusy, 0);
      check("dz_hilo", {hi, lo}, {32'd5, 32'd9});

      // MTHI coincident with start: start wins, HI unchanged
      run_op(2'b11, 32'd1, 32'd0, 0, 1'b1);
      check("wr_vs_start_hi", hi, 32'd5);

      // Illegal start and MTLO while busy
      run_op(2'b01, 32'd6, 32'd7, 5, 1'b0);
      check("inj_busy_lat", lat, 34);
      check("inj_busy_nbusy", nbusy, 33);
      check("inj_busy_ndone", ndone, 1);
      check("inj_busy_hilo", {hi, lo}, {32'd0, 32'd42});

      // Illegal start and MTLO in the done cycle
      run_op(2'b01, 32'd3, 32'd9, 34, 1'b0);
      check("inj_done_ndone", ndone, 1);
      check("inj_done_nbusy", nbusy, 33);
      check("inj_done_hilo", {hi, lo}, {32'd0, 32'd27});

      // Reset in cycle 10 of a MULT
      @(negedge clock);
      start = 1'b1;
      op    = 2'b00;
      a     = 32'hFFFF_FFF0;
      b     = 32'h0000_0100;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_hilo", {hi, lo}, 64'h0);
      @(negedge clock);
      reset = 1'b1;
      ndone_rst = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (done) ndone_rst++;
      end
      check("mid_rst_no_done", ndone_rst, 0);
      run_op(2'b01, 32'd3, 32'd5, 0, 1'b0);
      check("post_rst_lat", lat, 34);
      check("post_rst_hilo", {hi, lo}, {32'd0, 32'd15});

      // WIDTH=8 signed MULT 0x80 * 0x80
      @(negedge clock);
      start8 = 1'b1;
      op8    = 2'b00;
      a8     = 8'h80;
      b8     = 8'h80;
      @(posedge clock);
      #1;
      start8 = 1'b0;
      a8     = 8'h00;
      lat8   = -1;
      for (int k = 1; k <= 20; k++) begin
         if (done8 && lat8 < 0) lat8 = k;
         @(posedge clock);
         #1;
      end
      check("w8_lat", lat8, 10);
      check("w8_hilo", {hi8, lo8}, 16'h4000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
